// File: rtl/bullet_pool.sv
// Pool of upward-moving player bullets: spawns on shoot, advances on each game
// tick, frees a slot at the screen top, and flags pixels covered by a bullet.
module bullet_pool #(
  parameter int NUM_BULLETS = 8,
  parameter int BULLET_W    = 4,
  parameter int BULLET_H    = 8,
  parameter int SPEED       = 4,
  parameter int COOLDOWN    = 4,
  parameter int REIMU_W     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       shoot,
  input  logic       gameover,
  input  logic [9:0] reimux,
  input  logic [9:0] reimuy,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       valid,
  output logic       bullet_pix,
  output logic [3:0] active_cnt,
  output logic       fire_pulse
);

  localparam logic [10:0] X_OFF   = 11'(REIMU_W / 2 - BULLET_W / 2);
  localparam logic [10:0] X_MAX   = 11'(640 - BULLET_W);
  localparam logic [7:0]  CD_LOAD = (COOLDOWN > 0) ? 8'(COOLDOWN - 1) : 8'd0;

  logic [NUM_BULLETS-1:0] active;
  logic [9:0]             x [NUM_BULLETS];
  logic [9:0]             y [NUM_BULLETS];
  logic [7:0]             cooldown;

  logic                   free_found;
  logic [3:0]             free_idx;
  logic                   spawn;
  logic [10:0]            spawn_x_raw;
  logic [9:0]             spawn_x;
  logic [NUM_BULLETS-1:0] active_next;
  logic [3:0]             cnt_next;
  logic                   pix_hit;

  // Lowest free slot is chosen from the pre-tick state, so a slot despawning
  // on this tick cannot be reused until the following tick.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 4'd0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
    end
  end

  always_comb begin
    spawn = tick && shoot && !gameover && (cooldown == 8'd0) &&
            (reimuy >= 10'(BULLET_H)) && free_found;
    spawn_x_raw = {1'b0, reimux} + X_OFF;
    spawn_x     = (spawn_x_raw > X_MAX) ? X_MAX[9:0] : spawn_x_raw[9:0];
  end

  always_comb begin
    active_next = active;
    cnt_next    = 4'd0;
    if (gameover) begin
      active_next = '0;
    end else if (tick) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (active[i] && (y[i] < 10'(SPEED))) active_next[i] = 1'b0;
        if (spawn && (free_idx == 4'(i)))     active_next[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_BULLETS; i++) begin
      cnt_next = cnt_next + 4'(active_next[i]);
    end
  end

  // Hit test uses the pre-update slot state; 11-bit sums avoid wrap at the edges.
  always_comb begin
    pix_hit = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (active[i] &&
          ({1'b0, h_cnt} >= {1'b0, x[i]}) &&
          ({1'b0, h_cnt} <  ({1'b0, x[i]} + 11'(BULLET_W))) &&
          ({1'b0, v_cnt} >= {1'b0, y[i]}) &&
          ({1'b0, v_cnt} <  ({1'b0, y[i]} + 11'(BULLET_H)))) begin
        pix_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active     <= '0;
      cooldown   <= 8'd0;
      bullet_pix <= 1'b0;
      active_cnt <= 4'd0;
      fire_pulse <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x[i] <= 10'd0;
        y[i] <= 10'd0;
      end
    end else begin
      bullet_pix <= valid && pix_hit;
      active     <= active_next;
      active_cnt <= cnt_next;
      fire_pulse <= spawn;

      if (gameover) begin
        cooldown <= 8'd0;
      end else if (tick) begin
        if (spawn)                 cooldown <= CD_LOAD;
        else if (cooldown != 8'd0) cooldown <= cooldown - 8'd1;
      end

      if (tick && !gameover) begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
          if (spawn && (free_idx == 4'(i))) begin
            x[i] <= spawn_x;
            y[i] <= reimuy - 10'(BULLET_H);
          end else if (active[i] && (y[i] >= 10'(SPEED))) begin
            y[i] <= y[i] - 10'(SPEED);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: spawn, cooldown, fill, top despawn/reuse,
// edge clamps, gameover, reset mid-flight and pixel hit window.
module tb_bullet_pool;

  logic       clk = 1'b0;
  logic       rst, tick, shoot, gameover, valid;
  logic [9:0] reimux, reimuy, h_cnt, v_cnt;
  logic       bullet_pix, fire_pulse;
  logic [3:0] active_cnt;

  int compares = 0;
  int fails    = 0;

  always #5 clk = ~clk;

  bullet_pool dut (
    .clk(clk), .rst(rst), .tick(tick), .shoot(shoot), .gameover(gameover),
    .reimux(reimux), .reimuy(reimuy), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .valid(valid), .bullet_pix(bullet_pix), .active_cnt(active_cnt),
    .fire_pulse(fire_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic clear_pool();
    gameover = 1'b1;
    step();
    gameover = 1'b0;
    step();
  endtask

  task automatic probe(input string tag, input logic [9:0] h, input logic [9:0] v,
                       input logic vl, input logic exp);
    h_cnt = h;
    v_cnt = v;
    valid = vl;
    step();
    check(tag, 32'(bullet_pix), 32'(exp));
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; shoot = 1'b0; gameover = 1'b0; valid = 1'b0;
    reimux = 10'd0; reimuy = 10'd0; h_cnt = 10'd0; v_cnt = 10'd0;
    step();
    step();
    check("rst_cnt", 32'(active_cnt), 0);
    check("rst_fire", 32'(fire_pulse), 0);
    rst = 1'b0;
    probe("rst_pix_origin", 10'd0, 10'd0, 1'b1, 1'b0);

    // Single shot: x = 100+16-2 = 114, y = 400-8 = 392
    reimux = 10'd100; reimuy = 10'd400; shoot = 1'b1;
    do_tick();
    shoot = 1'b0;
    check("shot_fire", 32'(fire_pulse), 1);
    check("shot_cnt", 32'(active_cnt), 1);
    step();
    check("shot_fire_drop", 32'(fire_pulse), 0);
    probe("pix_tl", 10'd114, 10'd392, 1'b1, 1'b1);
    probe("pix_br", 10'd117, 10'd399, 1'b1, 1'b1);
    probe("pix_mid", 10'd115, 10'd395, 1'b1, 1'b1);
    probe("pix_left", 10'd113, 10'd392, 1'b1, 1'b0);
    probe("pix_right", 10'd118, 10'd392, 1'b1, 1'b0);
    probe("pix_below", 10'd114, 10'd400, 1'b1, 1'b0);
    probe("pix_above", 10'd114, 10'd391, 1'b1, 1'b0);
    probe("pix_invalid", 10'd114, 10'd392, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_tick();
    check("move_cnt", 32'(active_cnt), 1);
    probe("move_top", 10'd114, 10'd380, 1'b1, 1'b1);
    probe("move_above", 10'd114, 10'd379, 1'b1, 1'b0);
    probe("move_bot", 10'd114, 10'd387, 1'b1, 1'b1);
    probe("move_below", 10'd114, 10'd388, 1'b1, 1'b0);

    // Cooldown and fill: spawns on ticks 0,4,...,28 then full
    clear_pool();
    check("clear_cnt", 32'(active_cnt), 0);
    shoot = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_tick();
      check($sformatf("fill_fire_%0d", i), 32'(fire_pulse), ((i % 4 == 0) && (i < 32)) ? 1 : 0);
      check($sformatf("fill_cnt_%0d", i), 32'(active_cnt), (i < 32) ? (i / 4 + 1) : 8);
    end
    shoot = 1'b0;

    // Gameover: five bullets, cleared between ticks, cooldown reset
    clear_pool();
    shoot = 1'b1;
    for (int i = 0; i < 17; i++) do_tick();
    check("go_pre_cnt", 32'(active_cnt), 5);
    gameover = 1'b1;
    step();
    check("go_cnt", 32'(active_cnt), 0);
    do_tick();
    check("go_hold_fire", 32'(fire_pulse), 0);
    check("go_hold_cnt", 32'(active_cnt), 0);
    gameover = 1'b0;
    do_tick();
    check("go_rel_fire", 32'(fire_pulse), 1);
    check("go_rel_cnt", 32'(active_cnt), 1);

    // Reset mid-flight, even with tick and shoot asserted
    rst = 1'b1; tick = 1'b1;
    step();
    rst = 1'b0; tick = 1'b0; shoot = 1'b0;
    check("midrst_cnt", 32'(active_cnt), 0);
    check("midrst_fire", 32'(fire_pulse), 0);
    probe("midrst_pix", 10'd114, 10'd392, 1'b1, 1'b0);

    // Top despawn: reimuy=18 -> y 10, 6, 2, freed
    reimux = 10'd100; reimuy = 10'd18; shoot = 1'b1;
    do_tick();
    shoot = 1'b0;
    check("top_spawn_cnt", 32'(active_cnt), 1);
    do_tick();
    do_tick();
    check("top_y2_cnt", 32'(active_cnt), 1);
    probe("top_pix_y2", 10'd114, 10'd2, 1'b1, 1'b1);
    probe("top_pix_y9", 10'd114, 10'd9, 1'b1, 1'b1);
    probe("top_pix_y10", 10'd114, 10'd10, 1'b1, 1'b0);
    do_tick();
    check("top_free_cnt", 32'(active_cnt), 0);

    // Reuse while full: bullet A (y=128) frees on tick 33, refill on tick 34
    clear_pool();
    shoot = 1'b1;
    for (int i = 0; i < 35; i++) begin
      reimuy = (i == 0) ? 10'd136 : 10'd400;
      do_tick();
      check($sformatf("reuse_fire_%0d", i), 32'(fire_pulse),
            (((i % 4 == 0) && (i <= 28)) || (i == 34)) ? 1 : 0);
      check($sformatf("reuse_cnt_%0d", i), 32'(active_cnt),
            (i <= 28) ? (i / 4 + 1) : ((i == 33) ? 7 : 8));
    end
    shoot = 1'b0;

    // Edge conditions: low player blocks spawn; y=0 boundary; x clamp
    clear_pool();
    reimux = 10'd100; reimuy = 10'd5; shoot = 1'b1;
    do_tick();
    check("low_fire", 32'(fire_pulse), 0);
    check("low_cnt", 32'(active_cnt), 0);
    reimuy = 10'd8;
    do_tick();
    shoot = 1'b0;
    check("y0_fire", 32'(fire_pulse), 1);
    probe("y0_pix", 10'd114, 10'd0, 1'b1, 1'b1);
    clear_pool();
    reimux = 10'd630; reimuy = 10'd400; shoot = 1'b1;
    do_tick();
    shoot = 1'b0;
    check("clamp_fire", 32'(fire_pulse), 1);
    probe("clamp_l", 10'd636, 10'd392, 1'b1, 1'b1);
    probe("clamp_r", 10'd639, 10'd392, 1'b1, 1'b1);
    probe("clamp_out", 10'd635, 10'd392, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
